// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential adder: FSM state encoding,
// format constants, unpacked-operand struct and the unpack helper.
package fp32_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  // First biased exponent that no longer encodes a finite value
  localparam logic [9:0]  FP32_EXP_MAX = 10'(2 * FP32_BIAS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND
  } state_t;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W:0]   man;   // hidden bit included
    logic                  is_nan;
    logic                  is_inf;
    logic                  is_zero;
  } fp_unpk_t;

  // Subnormals (exp == 0) collapse to a signed zero with an all-zero mantissa.
  function automatic fp_unpk_t fp_unpack(input logic [31:0] x);
    fp_unpk_t u;
    u.sign    = x[31];
    u.is_zero = (x[30:23] == 8'h00);
    u.exp     = x[30:23];
    u.man     = u.is_zero ? 24'h0 : {1'b1, x[22:0]};
    u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    return u;
  endfunction

endpackage

// File: rtl/lzc28.sv
// Combinational leading-zero counter over 28 bits; all-zero input gives 28.
module lzc28 (
  input  logic [27:0] x,
  output logic [4:0]  cnt
);

  // Upward scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++)
      if (x[i]) cnt = 5'(27 - i);
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle FP32 adder, RNE rounding, subnormals flushed to zero.
// IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND, done pulses after ROUND.
// Optional macro FPADD_SUB_EN adds the 'sub' port selecting A - B.
module fp_add_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef FPADD_SUB_EN
  input  logic        sub,
`endif
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic [31:0] a_r, b_r, b_eff;
  fp_unpk_t    ua, ub;

  // ALIGN outputs
  logic        spec_vld, zero_sign, r_sign, eff_sub;
  logic [31:0] spec_val;
  logic [9:0]  r_exp;
  logic [26:0] big_m, small_m;
  // ADD / NORM outputs
  logic [27:0] sum_r;
  logic [26:0] nm;
  logic [9:0]  n_exp;
  logic        n_sign, n_zero;

`ifdef FPADD_SUB_EN
  logic sub_r;
  assign b_eff = {b_r[31] ^ sub_r, b_r[30:0]};
`else
  assign b_eff = b_r;
`endif

  assign busy = (state != S_IDLE);

  // ALIGN: order by magnitude, shift the small mantissa with sticky, flag specials
  logic        a_big, bg_sign, spec_vld_n, zero_sign_n;
  logic [7:0]  bg_exp, diff;
  logic [23:0] bg_man, sm_man;
  logic [26:0] sm_ext, sm_sh, sm_mask, small_n;
  logic [31:0] spec_val_n;
  always_comb begin
    a_big   = {ua.exp, ua.man} >= {ub.exp, ub.man};
    bg_sign = a_big ? ua.sign : ub.sign;
    bg_exp  = a_big ? ua.exp  : ub.exp;
    bg_man  = a_big ? ua.man  : ub.man;
    sm_man  = a_big ? ub.man  : ua.man;
    diff    = bg_exp - (a_big ? ub.exp : ua.exp);
    sm_ext  = {sm_man, 3'b000};
    sm_sh   = '0;
    sm_mask = '0;
    if (diff >= 8'd26) begin
      small_n = {26'h0, |sm_man};
    end else begin
      sm_sh   = sm_ext >> diff[4:0];
      sm_mask = (27'h1 << diff[4:0]) - 27'h1;
      small_n = {sm_sh[26:1], sm_sh[0] | (|(sm_ext & sm_mask))};
    end
    // Only -0 + -0 keeps a negative zero; every other exact zero is +0
    zero_sign_n = ua.is_zero & ub.is_zero & ua.sign & ub.sign;
    spec_vld_n  = 1'b1;
    spec_val_n  = FP32_QNAN;
    if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)))
      spec_val_n = FP32_QNAN;
    else if (ua.is_inf)
      spec_val_n = {ua.sign, 8'hFF, 23'h0};
    else if (ub.is_inf)
      spec_val_n = {ub.sign, 8'hFF, 23'h0};
    else
      spec_vld_n = 1'b0;
  end

  // NORM: carry -> shift right one, otherwise left-justify via the LZ count
  logic [4:0]  lz;
  logic [26:0] nm_n;
  logic [9:0]  ne_n;
  logic        n_zero_n, n_sign_n;
  lzc28 u_lzc (.x(sum_r), .cnt(lz));
  always_comb begin
    n_sign_n = r_sign;
    if (sum_r[27]) begin
      nm_n = {sum_r[27:2], sum_r[1] | sum_r[0]};
      ne_n = r_exp + 10'd1;
    end else begin
      nm_n = sum_r[26:0] << (lz - 5'd1);
      ne_n = r_exp + 10'd1 - {5'b0, lz};
    end
    n_zero_n = ne_n[9] || (ne_n == 10'd0);
    if (sum_r == 28'h0) begin
      n_zero_n = 1'b1;
      n_sign_n = zero_sign;
    end
  end

  // ROUND: nearest-even on guard/round/sticky, then pack or pick the special
  logic        rnd;
  logic [24:0] m25;
  logic [9:0]  e2;
  logic [22:0] frac;
  logic [31:0] res_n;
  always_comb begin
    rnd  = nm[2] & (nm[1] | nm[0] | nm[3]);
    m25  = {1'b0, nm[26:3]} + {24'h0, rnd};
    e2   = n_exp + {9'h0, m25[24]};
    frac = m25[24] ? m25[23:1] : m25[22:0];
    if (spec_vld)               res_n = spec_val;
    else if (n_zero)            res_n = {n_sign, 31'h0};
    else if (e2 >= FP32_EXP_MAX) res_n = {n_sign, 8'hFF, 23'h0};
    else                        res_n = {n_sign, e2[7:0], frac};
  end

  // Control FSM: stage sequencing plus the registered result/done outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      done   <= 1'b0;
      result <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:   if (start) state <= S_UNPACK;
        S_UNPACK: state <= S_ALIGN;
        S_ALIGN:  state <= S_ADD;
        S_ADD:    state <= S_NORM;
        S_NORM:   state <= S_ROUND;
        S_ROUND: begin
          result <= res_n;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: each stage loads what the next stage consumes
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start) begin
        a_r <= A;
        b_r <= B;
`ifdef FPADD_SUB_EN
        sub_r <= sub;
`endif
      end
      S_UNPACK: begin
        ua <= fp_unpack(a_r);
        ub <= fp_unpack(b_eff);
      end
      S_ALIGN: begin
        spec_vld  <= spec_vld_n;
        spec_val  <= spec_val_n;
        zero_sign <= zero_sign_n;
        r_sign    <= bg_sign;
        r_exp     <= {2'b00, bg_exp};
        big_m     <= {bg_man, 3'b000};
        small_m   <= small_n;
        eff_sub   <= ua.sign ^ ub.sign;
      end
      S_ADD: sum_r <= eff_sub ? ({1'b0, big_m} - {1'b0, small_m})
                              : ({1'b0, big_m} + {1'b0, small_m});
      S_NORM: begin
        nm     <= nm_n;
        n_exp  <= ne_n;
        n_sign <= n_sign_n;
        n_zero <= n_zero_n;
      end
      default: ;
    endcase
  end

endmodule
